mips_run_ctrl: RTL and testbench

//  Simulation run controller for the MIPS core bench. Stretches the bench reset into a

---
 rtl/mips_run_ctrl_pkg.sv | 38 +++
 rtl/mips_run_ctrl_if.sv | 36 +++
 rtl/mips_halt_det.sv | 55 +++++
 rtl/mips_run_ctrl.sv | 118 +++++++++++
 tb/tb_mips_run_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_run_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mips_run_ctrl_pkg
//   Shared definitions for the MIPS simulation run controller.
//   Contents:
//     ST_*           run-controller state codes (HOLD / RUN / DONE)
//     CAUSE_*        done_cause encodings
//     HALT_INSTR_DEF default halt encoding (beq $0,$0,-1)
//     pick_cause     priority encoder halt > stall > timeout
// ----------------------------------------------------------------------------
package mips_run_ctrl_pkg;

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_HALT    = 2'd1;
    localparam logic [1:0] CAUSE_STALL   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    localparam logic [31:0] HALT_INSTR_DEF = 32'h1000_ffff;

    // Highest-priority end-of-run cause among those firing this cycle.
    function automatic logic [1:0] pick_cause(input logic halt,
                                              input logic stall,
                                              input logic timeout);
        logic [1:0] cause;
        cause = CAUSE_NONE;
        if (halt)
            cause = CAUSE_HALT;
        else if (stall)
            cause = CAUSE_STALL;
        else if (timeout)
            cause = CAUSE_TIMEOUT;
        return cause;
    endfunction

endpackage

// File: rtl/mips_run_ctrl_if.sv
// ----------------------------------------------------------------------------
// mips_run_ctrl_if
//   Bundle between the run controller and the core/bench side.
//   Core -> controller : pc[31:0], instr[31:0], reg_we, reg_addr[4:0]
//   Controller -> core : cpu_reset, running, done, done_cause[1:0],
//                        cycle_cnt[CNT_W-1:0], wb_cnt[CNT_W-1:0]
//   Modports:
//     master - the run controller
//     slave  - the core / bench side
// ----------------------------------------------------------------------------
interface mips_run_ctrl_if #(
    parameter int CNT_W = 32
);

    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             reg_we;
    logic [4:0]       reg_addr;
    logic             cpu_reset;
    logic             running;
    logic             done;
    logic [1:0]       done_cause;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] wb_cnt;

    modport master (
        input  pc, instr, reg_we, reg_addr,
        output cpu_reset, running, done, done_cause, cycle_cnt, wb_cnt
    );

    modport slave (
        output pc, instr, reg_we, reg_addr,
        input  cpu_reset, running, done, done_cause, cycle_cnt, wb_cnt
    );

endinterface

// File: rtl/mips_halt_det.sv
// ----------------------------------------------------------------------------
// mips_halt_det
//   End-of-program detector: halt-instruction compare and repeated-PC stall
//   tracking. Hit outputs are combinational so the controller can act on the
//   same edge the condition is seen.
//   Ports:
//     i_clk, i_reset  clock, synchronous active-high reset
//     i_en            core is in RUN; tracking state advances only then
//     i_pc, i_instr   current PC and fetched instruction
//     o_halt_hit      instr matches HALT_INSTR (qualified by i_en)
//     o_stall_hit     PC repeated for STALL_LIMIT consecutive cycles
// ----------------------------------------------------------------------------
module mips_halt_det
    import mips_run_ctrl_pkg::*;
#(
    parameter int          STALL_LIMIT = 2,
    parameter logic [31:0] HALT_INSTR  = HALT_INSTR_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic        o_halt_hit,
    output logic        o_stall_hit
);

    logic [31:0] r_last_pc;
    logic        r_pc_valid;
    logic [31:0] r_stall_cnt;

    logic        w_same_pc;
    logic [31:0] w_stall_nxt;

    // The first RUN cycle has no previous PC, so pc_valid gates the compare.
    always_comb begin
        w_same_pc   = r_pc_valid && (i_pc == r_last_pc);
        w_stall_nxt = w_same_pc ? (r_stall_cnt + 32'd1) : '0;
        o_halt_hit  = i_en && (i_instr == HALT_INSTR);
        o_stall_hit = i_en && w_same_pc && (w_stall_nxt == 32'(STALL_LIMIT));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_pc   <= '0;
            r_pc_valid  <= 1'b0;
            r_stall_cnt <= '0;
        end else if (i_en) begin
            r_last_pc   <= i_pc;
            r_pc_valid  <= 1'b1;
            r_stall_cnt <= w_stall_nxt;
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// ----------------------------------------------------------------------------
// mips_run_ctrl
//   Simulation run controller for the MIPS core bench. Stretches the bench
//   reset into a RST_HOLD-cycle core reset, counts RUN cycles and GRF
//   writebacks, and ends the run on halt instruction, PC stall or timeout.
//   Ports:
//     i_clk    core clock
//     i_reset  synchronous active-high bench reset
//     io_bus   mips_run_ctrl_if.master
//                in : pc, instr, reg_we, reg_addr
//                out: cpu_reset, running, done, done_cause, cycle_cnt, wb_cnt
//   All outputs are registered.
// ----------------------------------------------------------------------------
module mips_run_ctrl
    import mips_run_ctrl_pkg::*;
#(
    parameter int          RST_HOLD    = 4,
    parameter int          MAX_CYCLES  = 10000,
    parameter int          STALL_LIMIT = 2,
    parameter logic [31:0] HALT_INSTR  = HALT_INSTR_DEF,
    parameter int          CNT_W       = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    mips_run_ctrl_if.master io_bus
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    logic [1:0]        r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_cpu_reset;
    logic              r_running;
    logic              r_done;
    logic [1:0]        r_done_cause;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  r_wb_cnt;

    logic              w_in_run;
    logic              w_halt_hit;
    logic              w_stall_hit;
    logic              w_timeout;
    logic              w_wb_inc;
    logic [1:0]        w_cause;

    mips_halt_det #(
        .STALL_LIMIT (STALL_LIMIT),
        .HALT_INSTR  (HALT_INSTR)
    ) u_halt_det (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_en        (w_in_run),
        .i_pc        (io_bus.pc),
        .i_instr     (io_bus.instr),
        .o_halt_hit  (w_halt_hit),
        .o_stall_hit (w_stall_hit)
    );

    // Timeout is seen one count early so cycle_cnt lands on MAX_CYCLES.
    always_comb begin
        w_in_run  = (r_state == ST_RUN);
        w_timeout = w_in_run && (r_cycle_cnt == CNT_W'(MAX_CYCLES - 1));
        w_wb_inc  = w_in_run && io_bus.reg_we && (io_bus.reg_addr != 5'd0);
        w_cause   = pick_cause(w_halt_hit, w_stall_hit, w_timeout);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_HOLD;
            r_hold_cnt   <= '0;
            r_cpu_reset  <= 1'b1;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_done_cause <= CAUSE_NONE;
            r_cycle_cnt  <= '0;
            r_wb_cnt     <= '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                        r_state     <= ST_RUN;
                        r_cpu_reset <= 1'b0;
                        r_running   <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    // The detecting cycle still contributes its own counts.
                    r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                    if (w_wb_inc)
                        r_wb_cnt <= r_wb_cnt + CNT_W'(1);
                    if (w_cause != CAUSE_NONE) begin
                        r_state      <= ST_DONE;
                        r_done       <= 1'b1;
                        r_running    <= 1'b0;
                        r_cpu_reset  <= 1'b1;
                        r_done_cause <= w_cause;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

    assign io_bus.cpu_reset  = r_cpu_reset;
    assign io_bus.running    = r_running;
    assign io_bus.done       = r_done;
    assign io_bus.done_cause = r_done_cause;
    assign io_bus.cycle_cnt  = r_cycle_cnt;
    assign io_bus.wb_cnt     = r_wb_cnt;

endmodule

// File: tb/tb_mips_run_ctrl.sv
module tb_mips_run_ctrl;

    localparam int          P_HOLD  = 4;
    localparam int          P_MAX   = 20;
    localparam int          P_STALL = 3;
    localparam logic [31:0] HALT    = 32'h1000_ffff;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        t_reset = 1'b1;
    logic [31:0] t_pc    = '0;
    logic [31:0] t_instr = '0;
    logic        t_we    = 1'b0;
    logic [4:0]  t_addr  = '0;

    mips_run_ctrl_if #(.CNT_W(32)) bus ();

    assign bus.pc       = t_pc;
    assign bus.instr    = t_instr;
    assign bus.reg_we   = t_we;
    assign bus.reg_addr = t_addr;

    mips_run_ctrl #(
        .RST_HOLD    (P_HOLD),
        .MAX_CYCLES  (P_MAX),
        .STALL_LIMIT (P_STALL),
        .HALT_INSTR  (HALT),
        .CNT_W       (32)
    ) dut (
        .i_clk   (clk),
        .i_reset (t_reset),
        .io_bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase flags, hold countdown and a short PC history.
    int          m_hold_left = 0;
    bit          m_run       = 1'b0;
    bit          m_done      = 1'b0;
    int          m_cause     = 0;
    int unsigned m_cycles    = 0;
    int unsigned m_wb        = 0;
    logic [31:0] m_hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit halt, stall, tmo;
        if (t_reset) begin
            m_hold_left = P_HOLD;
            m_run       = 1'b0;
            m_done      = 1'b0;
            m_cause     = 0;
            m_cycles    = 0;
            m_wb        = 0;
            m_hist.delete();
        end else if (m_done) begin
            // frozen until reset
        end else if (!m_run) begin
            m_hold_left--;
            if (m_hold_left == 0) m_run = 1'b1;
        end else begin
            m_cycles++;
            if (t_we && t_addr != 5'd0) m_wb++;
            halt  = (t_instr == HALT);
            stall = (m_hist.size() == P_STALL);
            foreach (m_hist[k]) if (m_hist[k] != t_pc) stall = 1'b0;
            tmo   = (m_cycles == P_MAX);
            m_hist.push_back(t_pc);
            if (m_hist.size() > P_STALL) void'(m_hist.pop_front());
            if (halt)       m_cause = 1;
            else if (stall) m_cause = 2;
            else if (tmo)   m_cause = 3;
            if (halt || stall || tmo) begin
                m_done = 1'b1;
                m_run  = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        chk("cpu_reset",  32'(bus.cpu_reset),  32'(!m_run));
        chk("running",    32'(bus.running),    32'(m_run));
        chk("done",       32'(bus.done),       32'(m_done));
        chk("done_cause", 32'(bus.done_cause), 32'(m_cause));
        chk("cycle_cnt",  bus.cycle_cnt,       m_cycles);
        chk("wb_cnt",     bus.wb_cnt,          m_wb);
    endtask

    task automatic step(input logic rst, input logic [31:0] pc, input logic [31:0] instr,
                        input logic we, input logic [4:0] addr);
        t_reset = rst;
        t_pc    = pc;
        t_instr = instr;
        t_we    = we;
        t_addr  = addr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic reset_and_hold();
        step(1'b1, 32'h0, NOP, 1'b0, 5'd0);
        for (int i = 0; i < P_HOLD; i++) step(1'b0, 32'h0, NOP, 1'b0, 5'd0);
    endtask

    logic [31:0] pc;
    logic [31:0] pcs6 [6];
    logic [4:0]  wb_addrs [4];

    initial begin
        // Reset state
        step(1'b1, 32'h0, NOP, 1'b0, 5'd0);
        step(1'b1, 32'h0, NOP, 1'b0, 5'd0);
        chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("rst_cycle_cnt", bus.cycle_cnt, 32'd0);

        // 1: HOLD stretch then counting
        for (int i = 0; i < P_HOLD; i++) begin
            step(1'b0, 32'h0, NOP, 1'b0, 5'd0);
            chk("t1_hold_cpu_reset", 32'(bus.cpu_reset), (i < P_HOLD - 1) ? 32'd1 : 32'd0);
        end
        chk("t1_running", 32'(bus.running), 32'd1);
        pc = 32'h0040_3000;
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, pc, NOP, 1'b0, 5'd0);
            chk("t1_cycle_cnt", bus.cycle_cnt, 32'(i));
            pc += 4;
        end

        // 2: halt on 10th RUN cycle, then frozen
        step(1'b0, pc, HALT, 1'b0, 5'd0);
        chk("t2_done", 32'(bus.done), 32'd1);
        chk("t2_cause", 32'(bus.done_cause), 32'd1);
        chk("t2_cycle_cnt", bus.cycle_cnt, 32'd10);
        chk("t2_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        for (int i = 0; i < 20; i++)
            step(1'b0, $urandom, ($urandom_range(1) != 0) ? HALT : $urandom,
                 1'b1, 5'($urandom_range(31, 1)));
        chk("t2_frozen_cycle", bus.cycle_cnt, 32'd10);
        chk("t2_frozen_wb", bus.wb_cnt, 32'd0);

        // 5/6: writebacks, ignored HOLD activity, reset mid-RUN
        wb_addrs = '{5'd0, 5'd5, 5'd0, 5'd31};
        step(1'b1, 32'h0, NOP, 1'b0, 5'd0);
        for (int i = 0; i < P_HOLD; i++) step(1'b0, 32'h0, HALT, 1'b1, 5'd5);
        chk("t5_hold_wb", bus.wb_cnt, 32'd0);
        chk("t5_hold_halt_ignored", 32'(bus.done), 32'd0);
        pc = 32'h3000;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, pc, NOP, (i < 4), (i < 4) ? wb_addrs[i] : 5'd0);
            pc += 4;
        end
        chk("t5_wb_cnt", bus.wb_cnt, 32'd2);
        step(1'b1, pc, NOP, 1'b1, 5'd7);
        chk("t6_rst_cycle", bus.cycle_cnt, 32'd0);
        chk("t6_rst_wb", bus.wb_cnt, 32'd0);
        chk("t6_rst_running", 32'(bus.running), 32'd0);
        for (int i = 0; i < P_HOLD; i++) step(1'b0, 32'h0, NOP, 1'b0, 5'd0);
        step(1'b0, 32'h3000, NOP, 1'b0, 5'd0);
        chk("t6_restart_cycle", bus.cycle_cnt, 32'd1);

        // 3: PC stall
        pcs6 = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008, 32'h3008};
        reset_and_hold();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, pcs6[i], NOP, 1'b0, 5'd0);
            chk("t3_done", 32'(bus.done), (i == 5) ? 32'd1 : 32'd0);
        end
        chk("t3_cause", 32'(bus.done_cause), 32'd2);
        chk("t3_cycle_cnt", bus.cycle_cnt, 32'd6);

        // 4: timeout at MAX_CYCLES, then halt winning on the same cycle
        for (int pass = 0; pass < 2; pass++) begin
            reset_and_hold();
            pc = 32'h0;
            for (int i = 1; i <= P_MAX; i++) begin
                step(1'b0, pc, (pass == 1 && i == P_MAX) ? HALT : NOP, 1'b0, 5'd0);
                pc += 4;
                if (i == P_MAX - 1) chk("t4_not_yet", 32'(bus.done), 32'd0);
            end
            chk("t4_cycle_cnt", bus.cycle_cnt, 32'(P_MAX));
            chk("t4_cause", 32'(bus.done_cause), (pass == 0) ? 32'd3 : 32'd1);
        end

        // Randomized runs against the model
        for (int run = 0; run < 15; run++) begin
            step(1'b1, 32'h0, NOP, 1'b0, 5'd0);
            pc = 32'h1000;
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(99) >= 45) pc += 4;
                step(($urandom_range(99) == 0),
                     pc,
                     ($urandom_range(99) < 3) ? HALT : $urandom,
                     $urandom_range(1),
                     ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
